ascon_permutation: RTL



---
 rtl/ascon_pkg.sv | 32 +++
 rtl/linear_diffusion_layer.sv | 21 ++
 rtl/substitution_layer.sv | 31 +++
 rtl/ascon_permutation.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation core.
// State is five 64-bit words; word 0 is S0.
package ascon_pkg;

  localparam int NUM_WORDS  = 5;
  localparam int WORD_WIDTH = 64;
  localparam int MAX_ROUNDS = 16;

  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
  typedef logic [3:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_fsm_e;

  localparam logic [7:0] ROUND_CONST [MAX_ROUNDS] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f,
    8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b
  };

  function automatic logic [WORD_WIDTH-1:0] ror64(
    input logic [WORD_WIDTH-1:0] x,
    input int unsigned           a
  );
    return (x >> a) | (x << (WORD_WIDTH - a));
  endfunction

endpackage

// File: rtl/linear_diffusion_layer.sv
// Ascon linear layer: each word XORed with two rotations of itself.
// Ports: state_i (ascon_state_t) in, state_o (ascon_state_t) out.
module linear_diffusion_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  assign state_o[0] = state_i[0]
    ^ ror64(state_i[0], 19) ^ ror64(state_i[0], 28);
  assign state_o[1] = state_i[1]
    ^ ror64(state_i[1], 61) ^ ror64(state_i[1], 39);
  assign state_o[2] = state_i[2]
    ^ ror64(state_i[2], 1) ^ ror64(state_i[2], 6);
  assign state_o[3] = state_i[3]
    ^ ror64(state_i[3], 10) ^ ror64(state_i[3], 17);
  assign state_o[4] = state_i[4]
    ^ ror64(state_i[4], 7) ^ ror64(state_i[4], 41);

endmodule

// File: rtl/substitution_layer.sv
// Bit-sliced Ascon 5-bit S-box applied to all 64 columns.
// Ports: state_i (ascon_state_t) in, state_o (ascon_state_t) out.
module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  logic [WORD_WIDTH-1:0] a0, a1, a2, a3, a4;
  logic [WORD_WIDTH-1:0] b0, b1, b2, b3, b4;

  assign a0 = state_i[0] ^ state_i[4];
  assign a1 = state_i[1];
  assign a2 = state_i[2] ^ state_i[1];
  assign a3 = state_i[3];
  assign a4 = state_i[4] ^ state_i[3];

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign state_o[0] = b0 ^ b4;
  assign state_o[1] = b1 ^ b0;
  assign state_o[2] = ~b2;
  assign state_o[3] = b3 ^ b2;
  assign state_o[4] = b4;

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[n] core, one round per cycle (two with
// ASCON_PERM_UNROLL2_EN), valid/ready in and out.
// Ports: clk_i, rst_i (sync, high), in_valid_i/in_ready_o,
// rounds_i, state_array_i, out_valid_o/out_ready_i,
// state_array_o, busy_o.
module ascon_permutation
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [4:0]   rounds_i,
  input  ascon_state_t state_array_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_array_o,
  output logic         busy_o
);

  perm_fsm_e    fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  round_idx_t   idx_q, idx_d;

  logic       req;
  logic [4:0] n_clamped;

  ascon_state_t ca0, sb0, ld0;

  always_comb begin
    ca0 = state_q;
    ca0[2][7:0] = state_q[2][7:0] ^ ROUND_CONST[idx_q];
  end

  substitution_layer u_sbox0 (
    .state_i (ca0),
    .state_o (sb0)
  );

  linear_diffusion_layer u_lin0 (
    .state_i (sb0),
    .state_o (ld0)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  ascon_state_t ca1, sb1, ld1;
  round_idx_t   idx_p1;

  assign idx_p1 = idx_q + 4'd1;

  always_comb begin
    ca1 = ld0;
    ca1[2][7:0] = ld0[2][7:0] ^ ROUND_CONST[idx_p1];
  end

  substitution_layer u_sbox1 (
    .state_i (ca1),
    .state_o (sb1)
  );

  linear_diffusion_layer u_lin1 (
    .state_i (sb1),
    .state_o (ld1)
  );
`endif

  assign in_ready_o = (fsm_q == IDLE)
                   || ((fsm_q == DONE) && out_ready_i);
  assign req        = in_valid_i && in_ready_o;
  assign n_clamped  = (rounds_i > 5'd16) ? 5'd16 : rounds_i;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (fsm_q)
      IDLE, DONE: begin
        if ((fsm_q == DONE) && out_ready_i) fsm_d = IDLE;
        if (req) begin
          state_d = state_array_i;
          // 16 - n wraps to 0 for n = 0; unused since we skip RUN
          idx_d   = round_idx_t'(5'd16 - n_clamped);
          fsm_d   = (n_clamped == 5'd0) ? DONE : RUN;
        end
      end
      RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
        // odd remainder: last cycle keeps only the first round
        if (idx_q == 4'd15) begin
          state_d = ld0;
          idx_d   = idx_q + 4'd1;
          fsm_d   = DONE;
        end else begin
          state_d = ld1;
          idx_d   = idx_q + 4'd2;
          if (idx_p1 == 4'd15) fsm_d = DONE;
        end
`else
        state_d = ld0;
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'd15) fsm_d = DONE;
`endif
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid_o   = (fsm_q == DONE);
  assign busy_o        = (fsm_q == RUN);
  assign state_array_o = state_q;

endmodule
